// File: rtl/median_axis_pkg.sv
// Shared types, limits and helpers for the median filter AXI4-Stream output stages.
package median_axis_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlankLine,
    StRow
  } median_out_state_t;

  localparam int unsigned MEDIAN_MIN_KERNEL = 3;
  localparam int unsigned MEDIAN_MAX_KERNEL = 15;

  // Leading (k-1) lines and (k-1) columns have no valid median yet.
  function automatic logic is_border(input int unsigned line, input int unsigned pix,
                                     input int unsigned k);
    return (line < k - 1) || (pix < k - 1);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer with valid/ready handshake on both sides.
// The head entry drives the outputs directly; in_ready depends only on stored occupancy.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new beat lands behind whatever remains.
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/median_m_axis_out.sv
// AXI4-Stream master output stage for the windowed median filters: frame markers, border
// blanking and skid-buffered backpressure. MEDIAN_M_AXIS_BORDER_VALUE_EN adds i_border_value.
module median_m_axis_out
  import median_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_CHANNELS = 1,
  parameter int unsigned KERNEL_SIZE  = 5,
  parameter int unsigned DIM_WIDTH    = 13
) (
  input  logic                               i_clk,
  input  logic                               i_areset,
  input  logic [DIM_WIDTH-1:0]               IMG_WIDTH,
  input  logic [DIM_WIDTH-1:0]               IMG_HEIGHT,
  input  logic [DATA_WIDTH*NUM_CHANNELS-1:0] i_pixel,
  input  logic                               i_pixel_valid,
  input  logic                               i_start_of_frame,
`ifdef MEDIAN_M_AXIS_BORDER_VALUE_EN
  input  logic [DATA_WIDTH-1:0]              i_border_value,
`endif
  output logic                               o_pixel_ready,
  output logic [DATA_WIDTH*NUM_CHANNELS-1:0] m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tuser,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic                               o_sof_resync
);

  localparam int unsigned PW = DATA_WIDTH * NUM_CHANNELS;

  median_out_state_t    state_q, state_d;
  logic [DIM_WIDTH-1:0] line_q, line_d;
  logic [DIM_WIDTH-1:0] pix_q, pix_d;
  logic [DIM_WIDTH-1:0] wlast_q, wlast_d;
  logic [DIM_WIDTH-1:0] hlast_q, hlast_d;
  logic                 resync_q, resync_d;

  logic          pixel_ready, accept, sof_ok, push;
  logic [PW-1:0] border_pix, beat_data;
  logic          beat_user, beat_last;

  assign accept = i_pixel_valid && pixel_ready;
  assign sof_ok = (IMG_WIDTH >= DIM_WIDTH'(KERNEL_SIZE)) &&
                  (IMG_HEIGHT >= DIM_WIDTH'(KERNEL_SIZE));

`ifdef MEDIAN_M_AXIS_BORDER_VALUE_EN
  logic [DATA_WIDTH-1:0] border_q, border_d, border_cur;

  // The SOF beat itself is blanked with the value being latched on that same edge.
  assign border_cur = i_start_of_frame ? i_border_value : border_q;
  assign border_pix = {NUM_CHANNELS{border_cur}};
  assign border_d   = (accept && i_start_of_frame && sof_ok) ? i_border_value : border_q;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) border_q <= '0;
    else          border_q <= border_d;
  end
`else
  assign border_pix = '0;
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    pix_d     = pix_q;
    wlast_d   = wlast_q;
    hlast_d   = hlast_q;
    resync_d  = 1'b0;
    push      = 1'b0;
    beat_data = border_pix;
    beat_user = 1'b0;
    beat_last = 1'b0;
    if (accept) begin
      if (i_start_of_frame) begin
        if (sof_ok) begin
          // Position (0,0) is always border since the kernel is at least 3 wide.
          push      = 1'b1;
          beat_user = 1'b1;
          wlast_d   = IMG_WIDTH - 1'b1;
          hlast_d   = IMG_HEIGHT - 1'b1;
          line_d    = '0;
          pix_d     = DIM_WIDTH'(1);
          state_d   = (KERNEL_SIZE > 1) ? StBlankLine : StRow;
          resync_d  = (state_q != StIdle);
        end else begin
          state_d = StIdle;
          line_d  = '0;
          pix_d   = '0;
        end
      end else if (state_q != StIdle) begin
        push      = 1'b1;
        beat_last = (pix_q == wlast_q);
        if (!is_border(32'(line_q), 32'(pix_q), KERNEL_SIZE)) beat_data = i_pixel;
        if (beat_last) begin
          pix_d = '0;
          if (line_q == hlast_q) begin
            state_d = StIdle;
            line_d  = '0;
          end else begin
            line_d  = line_q + 1'b1;
            state_d = (32'(line_q) + 1 >= KERNEL_SIZE - 1) ? StRow : StBlankLine;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q  <= StIdle;
      line_q   <= '0;
      pix_q    <= '0;
      wlast_q  <= '0;
      hlast_q  <= '0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      pix_q    <= pix_d;
      wlast_q  <= wlast_d;
      hlast_q  <= hlast_d;
      resync_q <= resync_d;
    end
  end

  assign o_sof_resync  = resync_q;
  assign o_pixel_ready = pixel_ready;

  axis_skid_buffer #(
    .WIDTH(PW + 2)
  ) u_skid (
    .clk      (i_clk),
    .rst      (i_areset),
    .in_data  ({beat_last, beat_user, beat_data}),
    .in_valid (push),
    .in_ready (pixel_ready),
    .out_data ({m_axis_tlast, m_axis_tuser, m_axis_tdata}),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready)
  );

endmodule
